// File: rtl/turn_sequencer.sv
// Round sequencer: cursor, per-unit SELECT/TARGET/UNIT_ANIM turns, then one ENEMY_ANIM phase.
// Latency: every state change is registered and visible one cycle after its pulse; anim phases last ANIM_DIV*ANIM_LEN cycles.
// Backpressure: none; pulses that do not apply to the current phase are dropped. Optional TURN_SEQ_SKIP_EN skips dead units.
module turn_sequencer #(
  parameter int N_UNITS  = 2,
  parameter int MAP_W    = 20,
  parameter int MAP_H    = 15,
  parameter int POS_W    = 9,
  parameter int ANIM_DIV = 1048576,
  parameter int ANIM_LEN = 16,
  parameter int CUR_X0   = 7,
  parameter int CUR_Y0   = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     move_left,
  input  logic                     move_right,
  input  logic                     move_up,
  input  logic                     move_down,
  input  logic                     select_pulse,
  input  logic                     end_pulse,
  input  logic [N_UNITS*POS_W-1:0] unit_pos,
  input  logic [N_UNITS-1:0]       unit_alive,
  output logic [4:0]               cursor_x,
  output logic [4:0]               cursor_y,
  output logic [POS_W-1:0]         selected_pos,
  output logic [1:0]               phase,
  output logic [2:0]               active_unit,
  output logic [POS_W-1:0]         active_pos,
  output logic [POS_W-1:0]         target_pos,
  output logic [3:0]               anim_count,
  output logic [7:0]               round_count,
  output logic                     turn_done
);

  localparam int PRE_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef enum logic [1:0] {
    PH_SELECT     = 2'd0,
    PH_TARGET     = 2'd1,
    PH_UNIT_ANIM  = 2'd2,
    PH_ENEMY_ANIM = 2'd3
  } phase_e;

  phase_e             phase_q, phase_d;
  logic [4:0]         cursor_x_q, cursor_x_d;
  logic [4:0]         cursor_y_q, cursor_y_d;
  logic [2:0]         active_unit_q, active_unit_d;
  logic [POS_W-1:0]   target_pos_q, target_pos_d;
  logic [3:0]         anim_count_q, anim_count_d;
  logic [PRE_W-1:0]   prescaler_q, prescaler_d;
  logic [7:0]         round_count_q, round_count_d;
  logic               turn_done_q, turn_done_d;

  // Successor unit after the active one, and first unit of a new round.
  logic [2:0] adv_unit, first_unit;
  logic       adv_none, first_none, cur_dead;

  assign selected_pos = POS_W'(32'(cursor_y_q) * MAP_W + 32'(cursor_x_q));
  assign cursor_x     = cursor_x_q;
  assign cursor_y     = cursor_y_q;
  assign phase        = phase_q;
  assign active_unit  = active_unit_q;
  assign target_pos   = target_pos_q;
  assign anim_count   = anim_count_q;
  assign round_count  = round_count_q;
  assign turn_done    = turn_done_q;

  // Position of the acting unit; enemy phase has no player position.
  always_comb begin
    active_pos = '0;
    if (phase_q != PH_ENEMY_ANIM) begin
      for (int k = 0; k < N_UNITS; k++) begin
        if (active_unit_q == 3'(k)) active_pos = unit_pos[k*POS_W +: POS_W];
      end
    end
  end

`ifdef TURN_SEQ_SKIP_EN
  // Next alive unit after the active one / from index 0; flag when none remain.
  always_comb begin
    adv_none   = 1'b1;
    adv_unit   = active_unit_q;
    first_none = 1'b1;
    first_unit = 3'd0;
    cur_dead   = 1'b0;
    for (int k = N_UNITS-1; k >= 0; k--) begin
      if (3'(k) > active_unit_q && unit_alive[k]) begin
        adv_none = 1'b0;
        adv_unit = 3'(k);
      end
      if (unit_alive[k]) begin
        first_none = 1'b0;
        first_unit = 3'(k);
      end
      if (active_unit_q == 3'(k) && !unit_alive[k]) cur_dead = 1'b1;
    end
  end
`else
  logic unused_alive;
  assign unused_alive = ^unit_alive;

  // Every unit takes a turn in index order.
  always_comb begin
    adv_none   = (active_unit_q == 3'(N_UNITS-1));
    adv_unit   = active_unit_q + 3'd1;
    first_none = 1'b0;
    first_unit = 3'd0;
    cur_dead   = 1'b0;
  end
`endif

  // Cursor steps only while a player is choosing; opposing pulses cancel.
  always_comb begin
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    if (phase_q == PH_SELECT || phase_q == PH_TARGET) begin
      if (move_left && !move_right && cursor_x_q != 5'd0)
        cursor_x_d = cursor_x_q - 5'd1;
      else if (move_right && !move_left && cursor_x_q != 5'(MAP_W-1))
        cursor_x_d = cursor_x_q + 5'd1;
      if (move_up && !move_down && cursor_y_q != 5'd0)
        cursor_y_d = cursor_y_q - 5'd1;
      else if (move_down && !move_up && cursor_y_q != 5'(MAP_H-1))
        cursor_y_d = cursor_y_q + 5'd1;
    end
  end

  // Phase sequencing, animation timing and round bookkeeping.
  always_comb begin
    logic do_adv;
    logic anim_tick;
    phase_d       = phase_q;
    active_unit_d = active_unit_q;
    target_pos_d  = target_pos_q;
    anim_count_d  = anim_count_q;
    prescaler_d   = '0;
    round_count_d = round_count_q;
    turn_done_d   = 1'b0;
    do_adv        = 1'b0;
    anim_tick     = (prescaler_q == PRE_W'(ANIM_DIV-1));
    case (phase_q)
      PH_SELECT: begin
        if (cur_dead)          do_adv = 1'b1;
        else if (select_pulse) phase_d = PH_TARGET;
        else if (end_pulse)    do_adv = 1'b1;
      end
      PH_TARGET: begin
        if (cur_dead)          do_adv = 1'b1;
        else if (select_pulse) phase_d = PH_SELECT;
        else if (end_pulse) begin
          phase_d      = PH_UNIT_ANIM;
          target_pos_d = selected_pos;
          anim_count_d = 4'd0;
        end
      end
      default: begin
        prescaler_d = anim_tick ? '0 : prescaler_q + PRE_W'(1);
        if (anim_tick) begin
          if (anim_count_q == 4'(ANIM_LEN-1)) begin
            anim_count_d = 4'd0;
            if (phase_q == PH_UNIT_ANIM) begin
              do_adv = 1'b1;
            end else begin
              turn_done_d   = 1'b1;
              round_count_d = round_count_q + 8'd1;
              if (first_none) begin
                active_unit_d = 3'd0;
                phase_d       = PH_ENEMY_ANIM;
              end else begin
                active_unit_d = first_unit;
                phase_d       = PH_SELECT;
              end
            end
          end else begin
            anim_count_d = anim_count_q + 4'd1;
          end
        end
      end
    endcase
    if (do_adv) begin
      anim_count_d = 4'd0;
      if (adv_none) begin
        phase_d = PH_ENEMY_ANIM;
      end else begin
        active_unit_d = adv_unit;
        phase_d       = PH_SELECT;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= PH_SELECT;
      cursor_x_q    <= 5'(CUR_X0);
      cursor_y_q    <= 5'(CUR_Y0);
      active_unit_q <= 3'd0;
      target_pos_q  <= '0;
      anim_count_q  <= 4'd0;
      prescaler_q   <= '0;
      round_count_q <= 8'd0;
      turn_done_q   <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      cursor_x_q    <= cursor_x_d;
      cursor_y_q    <= cursor_y_d;
      active_unit_q <= active_unit_d;
      target_pos_q  <= target_pos_d;
      anim_count_q  <= anim_count_d;
      prescaler_q   <= prescaler_d;
      round_count_q <= round_count_d;
      turn_done_q   <= turn_done_d;
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: directed round walk-through followed by random pulses.
// Expected observations are queued per cycle by a behavioural model; a monitor compares them.
// Honours TURN_SEQ_SKIP_EN in the model when the macro is defined for the build.
module tb_turn_sequencer;
  localparam int N_UNITS  = 2;
  localparam int MAP_W    = 20;
  localparam int MAP_H    = 15;
  localparam int POS_W    = 9;
  localparam int ANIM_DIV = 4;
  localparam int ANIM_LEN = 4;

  localparam logic [5:0] P_L = 6'b100000;
  localparam logic [5:0] P_R = 6'b010000;
  localparam logic [5:0] P_U = 6'b001000;
  localparam logic [5:0] P_D = 6'b000100;
  localparam logic [5:0] P_S = 6'b000010;
  localparam logic [5:0] P_E = 6'b000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic move_left = 1'b0, move_right = 1'b0, move_up = 1'b0, move_down = 1'b0;
  logic select_pulse = 1'b0, end_pulse = 1'b0;
  logic [N_UNITS*POS_W-1:0] unit_pos = '0;
  logic [N_UNITS-1:0]       unit_alive = '1;
  logic [4:0]       cursor_x, cursor_y;
  logic [POS_W-1:0] selected_pos, active_pos, target_pos;
  logic [1:0]       phase;
  logic [2:0]       active_unit;
  logic [3:0]       anim_count;
  logic [7:0]       round_count;
  logic             turn_done;

  turn_sequencer #(
    .N_UNITS(N_UNITS), .MAP_W(MAP_W), .MAP_H(MAP_H), .POS_W(POS_W),
    .ANIM_DIV(ANIM_DIV), .ANIM_LEN(ANIM_LEN), .CUR_X0(7), .CUR_Y0(7)
  ) dut (
    .clk(clk), .rst(rst),
    .move_left(move_left), .move_right(move_right), .move_up(move_up), .move_down(move_down),
    .select_pulse(select_pulse), .end_pulse(end_pulse),
    .unit_pos(unit_pos), .unit_alive(unit_alive),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .selected_pos(selected_pos),
    .phase(phase), .active_unit(active_unit), .active_pos(active_pos),
    .target_pos(target_pos), .anim_count(anim_count), .round_count(round_count),
    .turn_done(turn_done)
  );

  typedef struct packed {
    logic [4:0]       cx;
    logic [4:0]       cy;
    logic [POS_W-1:0] sp;
    logic [1:0]       ph;
    logic [2:0]       au;
    logic [POS_W-1:0] ap;
    logic [POS_W-1:0] tp;
    logic [3:0]       ac;
    logic [7:0]       rc;
    logic             td;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_td = 0;
  int seen_td = 0;

  logic [N_UNITS*POS_W-1:0] nxt_pos = 18'h0_2A_5F;
  logic [N_UNITS-1:0]       nxt_alive = '1;

  // Model state: game-level quantities, animation tracked as cycles elapsed in the phase.
  int m_x, m_y, m_ph, m_au, m_tp, m_rc, m_el;
  bit m_td;

  function automatic int next_actor(int from);
    for (int k = from; k < N_UNITS; k++) begin
`ifdef TURN_SEQ_SKIP_EN
      if (unit_alive[k])
`endif
      return k;
    end
    return -1;
  endfunction

  function automatic void model_step(logic [5:0] p, bit rs);
    bit l, r, u, d, s, e, adv, dead;
    int sel, k;
    {l, r, u, d, s, e} = p;
    if (rs) begin
      m_x = 7; m_y = 7; m_ph = 0; m_au = 0; m_tp = 0; m_rc = 0; m_el = 0; m_td = 0;
      return;
    end
    m_td = 0;
    adv  = 0;
    dead = 0;
    sel  = m_y * MAP_W + m_x;
`ifdef TURN_SEQ_SKIP_EN
    dead = (m_ph < 2) && !unit_alive[m_au];
`endif
    if (m_ph < 2) begin
      if (l && !r && m_x > 0) m_x--;
      if (r && !l && m_x < MAP_W-1) m_x++;
      if (u && !d && m_y > 0) m_y--;
      if (d && !u && m_y < MAP_H-1) m_y++;
    end
    if (m_ph == 0) begin
      if (dead) adv = 1;
      else if (s) m_ph = 1;
      else if (e) adv = 1;
    end else if (m_ph == 1) begin
      if (dead) adv = 1;
      else if (s) m_ph = 0;
      else if (e) begin m_ph = 2; m_tp = sel; m_el = 0; end
    end else begin
      m_el++;
      if (m_el == ANIM_DIV * ANIM_LEN) begin
        m_el = 0;
        if (m_ph == 2) adv = 1;
        else begin
          m_td = 1;
          m_rc = (m_rc + 1) % 256;
          k = next_actor(0);
          if (k < 0) begin m_au = 0; m_ph = 3; end
          else begin m_au = k; m_ph = 0; end
        end
      end
    end
    if (adv) begin
      k = next_actor(m_au + 1);
      m_el = 0;
      if (k < 0) m_ph = 3;
      else begin m_au = k; m_ph = 0; end
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    logic [N_UNITS*POS_W-1:0] pv;
    pv   = unit_pos;
    o.cx = 5'(m_x);
    o.cy = 5'(m_y);
    o.sp = POS_W'(m_y * MAP_W + m_x);
    o.ph = 2'(m_ph);
    o.au = 3'(m_au);
    o.ap = (m_ph == 3) ? '0 : pv[m_au*POS_W +: POS_W];
    o.tp = POS_W'(m_tp);
    o.ac = (m_ph >= 2) ? 4'(m_el / ANIM_DIV) : 4'd0;
    o.rc = 8'(m_rc);
    o.td = m_td;
    return o;
  endfunction

  task automatic drive(input logic [5:0] p, input bit rs = 1'b0);
    @(negedge clk);
    {move_left, move_right, move_up, move_down, select_pulse, end_pulse} = p;
    rst        = rs;
    unit_pos   = nxt_pos;
    unit_alive = nxt_alive;
    model_step(p, rs);
    if (m_td) exp_td++;
    exp_q.push_back(model_obs());
  endtask

  // Monitor: one registered observation per cycle, compared against the queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        obs_t e, a;
        e = exp_q.pop_front();
        a = {cursor_x, cursor_y, selected_pos, phase, active_unit, active_pos,
             target_pos, anim_count, round_count, turn_done};
        if (turn_done === 1'b1) seen_td++;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL obs @%0t: got x=%0d y=%0d sp=%0d ph=%0d au=%0d ap=%0d tp=%0d ac=%0d rc=%0d td=%0d | want x=%0d y=%0d sp=%0d ph=%0d au=%0d ap=%0d tp=%0d ac=%0d rc=%0d td=%0d",
                   $time, a.cx, a.cy, a.sp, a.ph, a.au, a.ap, a.tp, a.ac, a.rc, a.td,
                   e.cx, e.cy, e.sp, e.ph, e.au, e.ap, e.tp, e.ac, e.rc, e.td);
        end
      end
    end
  end

  initial begin
    drive(6'b0, 1'b1);
    drive(6'b0, 1'b1);
    // cursor clamping and opposing pulses
    repeat (8)  drive(P_L);
    repeat (25) drive(P_R);
    repeat (10) drive(P_U);
    repeat (20) drive(P_D);
    drive(P_U | P_D);
    drive(P_L | P_R);
    // unit 0: target (3,2) and attack; pulses during animation are ignored
    drive(P_S);
    repeat (16) drive(P_L);
    repeat (12) drive(P_U);
    drive(P_E);
    repeat (8) drive(P_L | P_U | P_S | P_E);
    repeat (9) drive(6'b0);
    // unit 1 ends its turn -> enemy phase -> next round
    drive(P_E);
    repeat (18) drive(6'b0);
    // select wins over end; select cancels targeting
    drive(P_S | P_E);
    drive(P_S);
    drive(P_E);
    drive(P_S);
    drive(P_R);
    drive(P_E);
    repeat (6) drive(6'b0);
    drive(P_D, 1'b1);
    drive(6'b0);
    // random play
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] p;
      p = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0)};
      if ($urandom_range(0, 49) == 0) nxt_pos = N_UNITS*POS_W'($urandom);
      if ($urandom_range(0, 99) == 0) nxt_alive = N_UNITS'($urandom);
      drive(p, ($urandom_range(0, 599) == 0));
    end
    drive(6'b0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d observations never checked, required 0", exp_q.size());
    end
    checks++;
    if (seen_td != exp_td) begin
      errors++;
      $display("FAIL turn_done_count: got %0d pulses, required %0d", seen_td, exp_td);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
